// File: rtl/instr_fetch_if.sv
// Fetch-unit signal bundle: control from the pipeline, instr_mem read port,
// and the valid/ready instruction stream towards decode.
interface instr_fetch_if #(
  parameter int ADDR_W = 7
);
  // control from the pipeline
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  // decode handshake: a transfer happens on a rising edge where
  // instr_valid and instr_ready are both 1; instr/instr_pc are stable
  // while instr_valid=1 and instr_ready=0
  logic              instr_ready;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  // instr_mem port: data arrives on mem_out the cycle after memRead
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [31:0]       mem_in;
  logic [31:0]       mem_out;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, instr_ready, mem_out,
    output instr_valid, instr, instr_pc, memRead, memWrite, address, mem_in
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, instr_ready, mem_out,
    input  instr_valid, instr, instr_pc, memRead, memWrite, address, mem_in
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: PC, single-cycle-latency reads from instr_mem,
// small prefetch FIFO, and redirect with flush/squash of the in-flight read.
module instr_fetch_unit #(
  parameter int ADDR_W   = 7,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] infl_pc;
  logic              inflight;

  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              head_valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [OW-1:0]     occupancy;
  logic              unused_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts the in-flight read as already holding a slot, so a
  // read only issues when its data is guaranteed somewhere to land.
  always_comb begin
    head_valid = (count != '0) & ~bus.redirect_valid & ~rst;
    pop        = head_valid & bus.instr_ready;
    push       = inflight & ~bus.redirect_valid;
    occupancy  = {1'b0, count} + OW'(inflight) - OW'(pop);
    issue      = bus.fetch_en & ~bus.redirect_valid & ~rst &
                 (occupancy < OW'(DEPTH));
  end

  assign bus.instr_valid = head_valid;
  assign bus.instr       = data_q[rd_ptr];
  assign bus.instr_pc    = pc_q[rd_ptr];
  assign bus.memRead     = issue;
  assign bus.address     = pc;
  assign bus.memWrite    = 1'b0;
  assign bus.mem_in      = '0;
  assign unused_bits     = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= ADDR_W'(RESET_PC);
      infl_pc  <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) infl_pc <= pc;
      if (bus.redirect_valid) begin
        pc     <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (issue) pc <= pc + ADDR_W'(4);
        if (push)  wr_ptr <= next_ptr(wr_ptr);
        if (pop)   rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_q[wr_ptr] <= bus.mem_out;
      pc_q[wr_ptr]   <= infl_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: synchronous instr_mem model, in-order
// scoreboard of expected instruction PCs, and cycle-exact port checks.
module tb_instr_fetch_unit;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(2), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  int          n_reads;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 7'h00) return 32'h00700813;
    if (a == 7'h3C) return 32'hFE1FF0EF;
    return {16'hC0DE, 9'h000, a};
  endfunction

  // instr_mem model: read data appears the cycle after memRead
  always @(posedge clk) begin
    if (bus.memRead) bus.mem_out <= mem_word(bus.address);
  end

  // scoreboard: every accepted instruction must be the next expected PC
  always @(negedge clk) begin
    if (bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pc", {25'b0, bus.instr_pc}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", {25'b0, bus.instr_pc}, mon_e);
        check("sb_instr", bus.instr, mem_word(mon_e[ADDR_W-1:0]));
      end
    end
    if (bus.memRead) begin
      check("addr_align", {30'b0, bus.address[1:0]}, 32'h0);
      check("mem_write", {31'b0, bus.memWrite}, 32'h0);
      check("mem_in", bus.mem_in, 32'h0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    exp_q.delete();
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rst_memread", {31'b0, bus.memRead}, 32'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.fetch_en = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (4) next_cycle();
    check(tag, exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    bus.mem_out = '0;

    // streaming from reset
    do_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_memread", {31'b0, bus.memRead}, 32'h1);
      check("t1_addr", {25'b0, bus.address}, 32'(4 * i));
      check("t1_valid", {31'b0, bus.instr_valid}, (i >= 2) ? 32'h1 : 32'h0);
      if (i == 2) begin
        check("t1_first_instr", bus.instr, 32'h00700813);
        check("t1_first_pc", {25'b0, bus.instr_pc}, 32'h0);
      end
      next_cycle();
    end
    drain("t1_drain");

    // backpressure: only DEPTH reads while decode stalls
    do_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b0;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h04);
    exp_q.push_back(32'h08);
    n_reads = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.memRead) n_reads++;
      next_cycle();
    end
    check("t2_reads", n_reads, 32'd2);
    @(negedge clk);
    check("t2_hold_valid", {31'b0, bus.instr_valid}, 32'h1);
    check("t2_hold_pc", {25'b0, bus.instr_pc}, 32'h0);
    next_cycle();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("t2_resume_addr", {25'b0, bus.address}, 32'h08);
    check("t2_resume_rd", {31'b0, bus.memRead}, 32'h1);
    next_cycle();
    drain("t2_drain");

    // redirect with a queued entry and a read in flight
    do_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b0;
    exp_q.push_back(32'h00);
    repeat (3) next_cycle();
    bus.instr_ready = 1'b1;
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 7'h3D;
    @(negedge clk);
    check("t3_redir_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("t3_redir_rd", {31'b0, bus.memRead}, 32'h0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    exp_q.push_back(32'h3C);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    @(negedge clk);
    check("t3_flushed", {31'b0, bus.instr_valid}, 32'h0);
    check("t3_new_addr", {25'b0, bus.address}, 32'h3C);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("t3_head_valid", {31'b0, bus.instr_valid}, 32'h1);
    check("t3_head_pc", {25'b0, bus.instr_pc}, 32'h3C);
    check("t3_head_instr", bus.instr, 32'hFE1FF0EF);
    next_cycle();
    drain("t3_drain");

    // PC wrap at the top of the address space
    do_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 7'h7C;
    @(negedge clk);
    check("t4_redir_rd", {31'b0, bus.memRead}, 32'h0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    exp_q.push_back(32'h7C);
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h04);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_wrap_addr", {25'b0, bus.address}, (32'h7C + 32'(4 * i)) & 32'h7F);
      next_cycle();
    end
    drain("t4_drain");

    // fetch_en dropped right after one issue
    do_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h04);
    @(negedge clk);
    check("t5_first_addr", {25'b0, bus.address}, 32'h0);
    next_cycle();
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_idle_rd", {31'b0, bus.memRead}, 32'h0);
      if (i == 1) check("t5_delivered", {31'b0, bus.instr_valid}, 32'h1);
      next_cycle();
    end
    bus.fetch_en = 1'b1;
    @(negedge clk);
    check("t5_resume_rd", {31'b0, bus.memRead}, 32'h1);
    check("t5_resume_addr", {25'b0, bus.address}, 32'h04);
    next_cycle();
    drain("t5_drain");

    // reset mid-operation with two entries queued
    do_reset();
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("t6_queued", {31'b0, bus.instr_valid}, 32'h1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("t6_rst_rd", {31'b0, bus.memRead}, 32'h0);
    next_cycle();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h04);
    @(negedge clk);
    check("t6_after_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("t6_restart_addr", {25'b0, bus.address}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("t6_second_addr", {25'b0, bus.address}, 32'h04);
    next_cycle();
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
